ets_delay_sweep: RTL
====================

# ets_delay_sweep

Sequencer that walks the PLL dynamic delay word across a programmable range for equivalent-time sampling. For each delay point it applies the delay, waits for the PLL to settle, opens a capture window for the sampler, then hands the point off downstream with a valid/ready handshake. Sits between the host control registers and the PLL `DYNAMICDELAY` input, and generalises the fixed-delay clock generator to parametrised width, dwell and single/continuous sweep modes.

## Interface
- `DELAY_WIDTH`, 8: width of the delay word and range inputs.
- `SETTLE_CYCLES`, 64: `clk` cycles waited after each delay change; must be ≥1.
- `CAPTURE_CYCLES`, 16: `clk` cycles `capture_en` is high per point; must be ≥1.
- `SWEEP_COUNT_WIDTH`, 16: width of the completed-sweep counter.

- `clk` in 1: sole clock.
- `resetb` in 1: synchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: stop the sweep and return to IDLE.
- `continuous` in 1: 0 = single sweep, 1 = wrap and repeat; sampled with `start`.
- `start_delay` in DELAY_WIDTH: first delay point; sampled with `start`.
- `stop_delay` in DELAY_WIDTH: last permitted delay point; sampled with `start`.
- `step` in DELAY_WIDTH: increment between points; 0 is treated as 1; sampled with `start`.
- `pll_lock` in 1: PLL lock indication; used only when `ETS_SWEEP_LOCK_WAIT_EN` is defined.
- `delay` out DELAY_WIDTH: registered delay word driven to the PLL.
- `capture_en` out 1: sampler capture window.
- `point_valid` out 1: a point is complete.
- `point_ready` in 1: downstream accepts the point.
- `point_delay` out DELAY_WIDTH: delay of the completed point.
- `point_index` out DELAY_WIDTH: zero-based point number within the current sweep.
- `sweep_count` out SWEEP_COUNT_WIDTH: number of completed sweeps since `start`; wraps.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a single sweep finishes.

## Operation
- States: IDLE → SETTLE → CAPTURE → HANDOFF → (SETTLE | IDLE).
- IDLE: when `start` is high, latch the config, load `delay` ← `start_delay`, clear `point_index` and `sweep_count`, and go to SETTLE.
- SETTLE: count `SETTLE_CYCLES` cycles, then go to CAPTURE.
- CAPTURE: `capture_en` is high for exactly `CAPTURE_CYCLES` cycles. Then `point_valid` is set, `point_delay` ← `delay`, and the state goes to HANDOFF.
- HANDOFF: hold `point_valid` and the point outputs until `point_ready` is high. On acceptance, compute `next = delay + step` in DELAY_WIDTH+1 bits.
  - If `next` ≤ `stop_delay`: `delay` ← `next`, `point_index`+1, go to SETTLE.
  - Else, continuous mode: `delay` ← `start_delay`, `point_index` ← 0, `sweep_count`+1, go to SETTLE.
  - Else, single mode: `sweep_count`+1, pulse `done`, go to IDLE. `delay` keeps its last value.
- `start_delay` > `stop_delay`: the sweep is exactly one point at `start_delay`.
- `abort` (any non-IDLE state): next cycle is IDLE with `capture_en` = 0 and `point_valid` = 0; `done` is not pulsed; `delay` is held. `abort` has priority over `point_ready` in the same cycle. `abort` with `start` in IDLE: `abort` wins and no sweep starts.
- `start` is ignored while `busy`.
- Reset: state IDLE; `delay`, `point_delay`, `point_index` and `sweep_count` are 0; `capture_en`, `point_valid`, `busy` and `done` are 0.

## Timing
- All outputs are registered. `delay` changes on the clock edge after the `start` cycle, and on the edge after the handshake cycle.
- `capture_en` rises exactly `SETTLE_CYCLES` cycles after `delay` changes (lock wait disabled).
- `point_valid` rises on the cycle after the last `capture_en` cycle.
- The handshake completes on a cycle with `point_valid` and `point_ready` both high; `point_valid` drops on the next edge.
- Minimum per-point period is SETTLE_CYCLES + CAPTURE_CYCLES + 1 cycles.

## Configuration
- `ETS_SWEEP_LOCK_WAIT_EN` defined: SETTLE exits only when the settle count has expired and `pll_lock` is high. Loss of `pll_lock` during CAPTURE restarts SETTLE with a reloaded count and drops `capture_en`.
- Not defined: `pll_lock` is ignored and SETTLE is purely counted.

## Test plan
- Reset check: `resetb` low for 3 cycles → every output is 0 and `busy` = 0.
- Single sweep: start 0x10, stop 0x14, step 2, `point_ready` tied 1 → points at 0x10, 0x12, 0x14 with indices 0..2, one `done` pulse, `sweep_count` = 1.
- Backpressure: `point_ready` held low 10 cycles → `point_valid` and `point_delay` stable, `delay` unchanged, no new `capture_en`.
- Continuous mode: start 0xFE, stop 0xFF, step 1 → sequence 0xFE, 0xFF, 0xFE, …; `sweep_count` increments at each wrap; no `done`; no 9-bit overflow.
- Abort mid-CAPTURE, then step 0 with start 5 > stop 3 → `capture_en` drops next cycle with no `done`; the second sweep gives a single point at 5.
- With `ETS_SWEEP_LOCK_WAIT_EN`: `pll_lock` low for 100 cycles after settle → no `capture_en` until lock; a lock drop during capture restarts the settle count.

Source files
------------

// File: rtl/ets_delay_sweep.sv
// ets_delay_sweep: steps the PLL dynamic delay word across a range, settling and capturing at each point.
// Optional build macro ETS_SWEEP_LOCK_WAIT_EN gates settle exit and capture on pll_lock.
`default_nettype none

module ets_delay_sweep #(
   parameter int DELAY_WIDTH       = 8,
   parameter int SETTLE_CYCLES     = 64,
   parameter int CAPTURE_CYCLES    = 16,
   parameter int SWEEP_COUNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         resetb,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         continuous,
   input  logic [DELAY_WIDTH-1:0]       start_delay,
   input  logic [DELAY_WIDTH-1:0]       stop_delay,
   input  logic [DELAY_WIDTH-1:0]       step,
   input  logic                         pll_lock,
   output logic [DELAY_WIDTH-1:0]       delay,
   output logic                         capture_en,
   output logic                         point_valid,
   input  logic                         point_ready,
   output logic [DELAY_WIDTH-1:0]       point_delay,
   output logic [DELAY_WIDTH-1:0]       point_index,
   output logic [SWEEP_COUNT_WIDTH-1:0] sweep_count,
   output logic                         busy,
   output logic                         done
);

   localparam int MAX_CYC = (SETTLE_CYCLES > CAPTURE_CYCLES) ? SETTLE_CYCLES : CAPTURE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CAPTURE_LOAD = CNT_W'(CAPTURE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HANDOFF = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [DELAY_WIDTH-1:0]       delay_q, delay_d;
   logic [DELAY_WIDTH-1:0]       start_cfg_q, start_cfg_d;
   logic [DELAY_WIDTH-1:0]       stop_cfg_q, stop_cfg_d;
   logic [DELAY_WIDTH-1:0]       step_cfg_q, step_cfg_d;
   logic                         cont_q, cont_d;
   logic                         capture_en_q, capture_en_d;
   logic                         point_valid_q, point_valid_d;
   logic [DELAY_WIDTH-1:0]       point_delay_q, point_delay_d;
   logic [DELAY_WIDTH-1:0]       point_index_q, point_index_d;
   logic [SWEEP_COUNT_WIDTH-1:0] sweep_count_q, sweep_count_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;

   logic                         lock_ok;
   logic [DELAY_WIDTH:0]         next_delay;

`ifdef ETS_SWEEP_LOCK_WAIT_EN
   assign lock_ok = pll_lock;
`else
   logic unused_pll_lock;
   assign unused_pll_lock = pll_lock;
   assign lock_ok         = 1'b1;
`endif

   // One extra bit so a step past the top of the range is seen as overflow, not wrap.
   assign next_delay = {1'b0, delay_q} + {1'b0, step_cfg_q};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      delay_d       = delay_q;
      start_cfg_d   = start_cfg_q;
      stop_cfg_d    = stop_cfg_q;
      step_cfg_d    = step_cfg_q;
      cont_d        = cont_q;
      capture_en_d  = capture_en_q;
      point_valid_d = point_valid_q;
      point_delay_d = point_delay_q;
      point_index_d = point_index_q;
      sweep_count_d = sweep_count_q;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               start_cfg_d   = start_delay;
               stop_cfg_d    = stop_delay;
               step_cfg_d    = (step == '0) ? DELAY_WIDTH'(1) : step;
               cont_d        = continuous;
               delay_d       = start_delay;
               point_index_d = '0;
               sweep_count_d = '0;
               cnt_d         = SETTLE_LOAD;
               state_d       = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (lock_ok) begin
               cnt_d        = CAPTURE_LOAD;
               capture_en_d = 1'b1;
               state_d      = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (!lock_ok) begin
               cnt_d        = SETTLE_LOAD;
               capture_en_d = 1'b0;
               state_d      = ST_SETTLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               capture_en_d  = 1'b0;
               point_valid_d = 1'b1;
               point_delay_d = delay_q;
               state_d       = ST_HANDOFF;
            end
         end
         ST_HANDOFF: begin
            if (point_ready) begin
               point_valid_d = 1'b0;
               if (next_delay <= {1'b0, stop_cfg_q}) begin
                  delay_d       = next_delay[DELAY_WIDTH-1:0];
                  point_index_d = point_index_q + 1'b1;
                  cnt_d         = SETTLE_LOAD;
                  state_d       = ST_SETTLE;
               end else if (cont_q) begin
                  delay_d       = start_cfg_q;
                  point_index_d = '0;
                  sweep_count_d = sweep_count_q + 1'b1;
                  cnt_d         = SETTLE_LOAD;
                  state_d       = ST_SETTLE;
               end else begin
                  sweep_count_d = sweep_count_q + 1'b1;
                  done_d        = 1'b1;
                  state_d       = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides everything above, including a same-cycle handshake.
      if (abort && (state_q != ST_IDLE)) begin
         state_d       = ST_IDLE;
         capture_en_d  = 1'b0;
         point_valid_d = 1'b0;
         done_d        = 1'b0;
         delay_d       = delay_q;
         point_index_d = point_index_q;
         sweep_count_d = sweep_count_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         delay_q       <= '0;
         start_cfg_q   <= '0;
         stop_cfg_q    <= '0;
         step_cfg_q    <= '0;
         cont_q        <= 1'b0;
         capture_en_q  <= 1'b0;
         point_valid_q <= 1'b0;
         point_delay_q <= '0;
         point_index_q <= '0;
         sweep_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         delay_q       <= delay_d;
         start_cfg_q   <= start_cfg_d;
         stop_cfg_q    <= stop_cfg_d;
         step_cfg_q    <= step_cfg_d;
         cont_q        <= cont_d;
         capture_en_q  <= capture_en_d;
         point_valid_q <= point_valid_d;
         point_delay_q <= point_delay_d;
         point_index_q <= point_index_d;
         sweep_count_q <= sweep_count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign delay       = delay_q;
   assign capture_en  = capture_en_q;
   assign point_valid = point_valid_q;
   assign point_delay = point_delay_q;
   assign point_index = point_index_q;
   assign sweep_count = sweep_count_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

`default_nettype wire
